// File: rtl/life_col_n.sv
// Parametrised column of Conway B3/S23 cells with masked load, scan chain,
// population count, change flag and generation counter.
module life_col_n #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned WRAP  = 0,
  parameter int unsigned GEN_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ROWS-1:0]              w_col,
  input  logic [ROWS-1:0]              e_col,
  input  logic                         n,
  input  logic                         nw,
  input  logic                         ne,
  input  logic                         s,
  input  logic                         sw,
  input  logic                         se,
  input  logic                         write_enb,
  input  logic [ROWS-1:0]              wr_mask,
  input  logic [ROWS-1:0]              val,
  input  logic                         scan_en,
  input  logic                         scan_in,
  output logic                         scan_out,
  input  logic                         enable,
  output logic [ROWS-1:0]              alive_col,
  output logic [$clog2(ROWS+1)-1:0]    pop_count,
  output logic                         changed,
  output logic [GEN_W-1:0]             gen_count
);

  localparam int unsigned PC_W    = $clog2(ROWS + 1);
  localparam bit          WRAP_EN = (WRAP != 0);

  logic [ROWS-1:0]  alive_q, alive_d;
  logic [PC_W-1:0]  pop_q, pop_d;
  logic             changed_q, changed_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  // Columns extended by one row above (index 0) and below (index ROWS+1)
  logic [ROWS+1:0]  col_x, w_x, e_x;
  logic [3:0]       nbr_cnt [ROWS];
  logic [ROWS-1:0]  step_c;

  always_comb begin
    col_x = {WRAP_EN ? alive_q[0] : s,  alive_q, WRAP_EN ? alive_q[ROWS-1] : n};
    w_x   = {WRAP_EN ? w_col[0]   : sw, w_col,   WRAP_EN ? w_col[ROWS-1]   : nw};
    e_x   = {WRAP_EN ? e_col[0]   : se, e_col,   WRAP_EN ? e_col[ROWS-1]   : ne};
    step_c = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      nbr_cnt[i] = 4'(col_x[i]) + 4'(col_x[i+2])
                 + 4'(w_x[i])   + 4'(w_x[i+1])   + 4'(w_x[i+2])
                 + 4'(e_x[i])   + 4'(e_x[i+1])   + 4'(e_x[i+2]);
      step_c[i]  = (nbr_cnt[i] == 4'd3) | (alive_q[i] & (nbr_cnt[i] == 4'd2));
    end
  end

  // One action per cycle: write beats scan beats step
  always_comb begin
    alive_d   = alive_q;
    changed_d = changed_q;
    gen_d     = gen_q;
    pop_d     = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      pop_d = pop_d + PC_W'(alive_q[i]);
    end
    if (write_enb) begin
      alive_d = (alive_q & ~wr_mask) | (val & wr_mask);
    end else if (scan_en) begin
      alive_d = {alive_q[ROWS-2:0], scan_in};
    end else if (enable) begin
      alive_d   = step_c;
      changed_d = (step_c != alive_q);
      gen_d     = gen_q + GEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive_q   <= '0;
      pop_q     <= '0;
      changed_q <= 1'b0;
      gen_q     <= '0;
    end else begin
      alive_q   <= alive_d;
      pop_q     <= pop_d;
      changed_q <= changed_d;
      gen_q     <= gen_d;
    end
  end

  assign alive_col = alive_q;
  assign pop_count = pop_q;
  assign changed   = changed_q;
  assign gen_count = gen_q;
  assign scan_out  = alive_q[ROWS-1];

endmodule

// File: tb/tb_life_col_n.sv
// Bench for life_col_n: a non-wrapping and a wrapping column driven in parallel
// and compared against a neighbourhood-enumerating Game-of-Life model.
module tb_life_col_n;

  localparam int R = 8;

  logic clk, reset;
  logic [R-1:0] w_col, e_col, val, wr_mask;
  logic n, nw, ne, s, sw, se, write_enb, scan_en, scan_in, enable;

  logic [R-1:0] alive_a, alive_b;
  logic [3:0]   pop_a, pop_b;
  logic         chg_a, chg_b, so_a, so_b;
  logic [7:0]   gen_a, gen_b;

  int checks = 0;
  int failures = 0;

  logic [R-1:0] m_alive [2];
  logic [7:0]   m_gen   [2];
  logic         m_chg   [2];
  logic [3:0]   m_pop   [2];

  life_col_n #(.ROWS(R), .WRAP(0), .GEN_W(8)) dut_a (
    .clk(clk), .reset(reset), .w_col(w_col), .e_col(e_col),
    .n(n), .nw(nw), .ne(ne), .s(s), .sw(sw), .se(se),
    .write_enb(write_enb), .wr_mask(wr_mask), .val(val),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(so_a), .enable(enable),
    .alive_col(alive_a), .pop_count(pop_a), .changed(chg_a), .gen_count(gen_a));

  life_col_n #(.ROWS(R), .WRAP(1), .GEN_W(8)) dut_b (
    .clk(clk), .reset(reset), .w_col(w_col), .e_col(e_col),
    .n(n), .nw(nw), .ne(ne), .s(s), .sw(sw), .se(se),
    .write_enb(write_enb), .wr_mask(wr_mask), .val(val),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(so_b), .enable(enable),
    .alive_col(alive_b), .pop_count(pop_b), .changed(chg_b), .gen_count(gen_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input logic [R-1:0] a, w, e, input int row, input int dc);
    if (dc < 0) return w[row];
    if (dc == 0) return a[row];
    return e[row];
  endfunction

  // Enumerate the 8 neighbours of every cell directly from the rule
  function automatic logic [R-1:0] life_next(input logic [R-1:0] a, w, e,
      input logic pn, pnw, pne, ps, psw, pse, input bit wrap);
    logic [R-1:0] r;
    int cnt, rr;
    logic v;
    r = '0;
    for (int i = 0; i < R; i++) begin
      cnt = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (dr == 0 && dc == 0) continue;
          rr = i + dr;
          if (rr >= 0 && rr < R) v = pick(a, w, e, rr, dc);
          else if (wrap) v = pick(a, w, e, (rr + R) % R, dc);
          else if (rr < 0) v = (dc < 0) ? pnw : (dc == 0) ? pn : pne;
          else v = (dc < 0) ? psw : (dc == 0) ? ps : pse;
          cnt += int'(v);
        end
      end
      r[i] = (cnt == 3) || (a[i] && cnt == 2);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_alive[k] = '0; m_gen[k] = '0; m_chg[k] = 1'b0; m_pop[k] = '0;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_alive_a"}, 32'(alive_a), 32'(m_alive[0]));
    chk({ph, "_alive_b"}, 32'(alive_b), 32'(m_alive[1]));
    chk({ph, "_pop_a"},   32'(pop_a),   32'(m_pop[0]));
    chk({ph, "_pop_b"},   32'(pop_b),   32'(m_pop[1]));
    chk({ph, "_chg_a"},   32'(chg_a),   32'(m_chg[0]));
    chk({ph, "_chg_b"},   32'(chg_b),   32'(m_chg[1]));
    chk({ph, "_gen_a"},   32'(gen_a),   32'(m_gen[0]));
    chk({ph, "_gen_b"},   32'(gen_b),   32'(m_gen[1]));
  endtask

  // Advance the model on the current inputs, clock once, compare
  task automatic tick(input string ph);
    logic [R-1:0] nx;
    chk({ph, "_scan_out_a"}, 32'(so_a), 32'(m_alive[0][R-1]));
    chk({ph, "_scan_out_b"}, 32'(so_b), 32'(m_alive[1][R-1]));
    for (int k = 0; k < 2; k++) begin
      m_pop[k] = 4'($countones(m_alive[k]));
      if (write_enb) begin
        for (int i = 0; i < R; i++) if (wr_mask[i]) m_alive[k][i] = val[i];
      end else if (scan_en) begin
        m_alive[k] = {m_alive[k][R-2:0], scan_in};
      end else if (enable) begin
        nx = life_next(m_alive[k], w_col, e_col, n, nw, ne, s, sw, se, k == 1);
        m_chg[k]   = (nx != m_alive[k]);
        m_alive[k] = nx;
        m_gen[k]   = m_gen[k] + 8'd1;
      end
    end
    @(posedge clk); #1;
    check_all(ph);
  endtask

  task automatic idle_inputs();
    w_col = '0; e_col = '0; val = '0; wr_mask = '0;
    {n, nw, ne, s, sw, se} = '0;
    write_enb = 0; scan_en = 0; scan_in = 0; enable = 0;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  logic [7:0] scan_bits;

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    reset = 1'b1;
    tick("rst_idle");

    // Vertical blinker collapses to its middle cell
    val = 8'h1C; wr_mask = 8'hFF; write_enb = 1; tick("p1_wr");
    write_enb = 0; enable = 1; tick("p1_step");
    chk("p1_alive_const", 32'(alive_a), 32'h08);
    chk("p1_chg_const", 32'(chg_a), 32'h1);
    chk("p1_gen_const", 32'(gen_a), 32'h1);
    enable = 0; tick("p1_idle");
    chk("p1_pop_const", 32'(pop_a), 32'h1);

    // Birth from the west neighbour column, then isolation
    reset_pulse();
    w_col = 8'h38; enable = 1; tick("p2_s1");
    chk("p2_birth_const", 32'(alive_a), 32'h10);
    w_col = 8'h00; tick("p2_s2");
    chk("p2_die_const", 32'(alive_a), 32'h00);
    chk("p2_gen_const", 32'(gen_a), 32'h2);
    enable = 0;

    // Top/bottom wrap contrast
    reset_pulse();
    val = 8'h83; wr_mask = 8'hFF; write_enb = 1; tick("p3_wr");
    write_enb = 0; enable = 1; tick("p3_step");
    chk("p3_nowrap_const", 32'(alive_a), 32'h00);
    chk("p3_wrap_const", 32'(alive_b), 32'h01);
    enable = 0;

    // Scan in 0xA5, then scan it back out
    reset_pulse();
    scan_bits = 8'b1010_0101;
    scan_en = 1;
    for (int i = 0; i < R; i++) begin
      scan_in = scan_bits[R-1-i];
      tick("p4_in");
    end
    chk("p4_loaded_const", 32'(alive_a), 32'hA5);
    chk("p4_gen_const", 32'(gen_a), 32'h0);
    scan_in = 0;
    for (int i = 0; i < R; i++) begin
      chk("p4_scan_out_seq", 32'(so_a), 32'(scan_bits[R-1-i]));
      tick("p4_out");
    end
    chk("p4_empty_const", 32'(alive_a), 32'h00);
    scan_en = 0;

    // Write wins over scan and step; mask limits affected rows
    val = 8'hFF; wr_mask = 8'hFF; write_enb = 1; tick("p5_fill");
    val = 8'h00; wr_mask = 8'h0F; scan_en = 1; enable = 1; tick("p5_prio");
    chk("p5_alive_const", 32'(alive_a), 32'hF0);
    chk("p5_gen_const", 32'(gen_a), 32'h0);
    idle_inputs();

    // Randomised mix of loads, shifts and steps
    for (int c = 0; c < 400; c++) begin
      w_col = 8'($urandom); e_col = 8'($urandom);
      {n, nw, ne, s, sw, se} = 6'($urandom);
      val = 8'($urandom); wr_mask = 8'($urandom);
      write_enb = ($urandom_range(0, 7) == 0);
      scan_en   = ($urandom_range(0, 7) == 0);
      scan_in   = 1'($urandom);
      enable    = ($urandom_range(0, 1) == 1);
      tick("rnd");
    end
    idle_inputs();

    // Asynchronous reset between edges while stepping
    val = 8'h3C; wr_mask = 8'hFF; write_enb = 1; tick("p6_wr");
    write_enb = 0; enable = 1; w_col = 8'h5A;
    for (int i = 0; i < 3; i++) tick("p6_run");
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_all("p6_async");
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    tick("p6_hold");
    chk("p6_hold_const", 32'(alive_a), 32'h00);

    // Generation counter wraps at 2^8
    enable = 1;
    for (int i = 0; i < 255; i++) tick("p7_cnt");
    chk("p7_gen255_const", 32'(gen_a), 32'hFF);
    tick("p7_wrap");
    chk("p7_gen_wrap_const", 32'(gen_a), 32'h00);
    enable = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
